// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a FIFO, issues them one at a time and returns each captured result
// Ports: clk/rst (sync, active-high); cmd_* valid/ready command in; alu_* pins to the ALU (alu_rstn active-low);
//        alu_result from the ALU; rsp_* valid/ready response out; busy = activity flag; rsp_count = completed responses
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int RES_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op1,
    input  logic [3:0]       cmd_op2,
    input  logic [2:0]       cmd_opcode,
    output logic             alu_rstn,
    output logic [3:0]       alu_op1,
    output logic [3:0]       alu_op2,
    output logic [2:0]       alu_opcode,
    input  logic [RES_W-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic [2:0]       rsp_opcode,
    output logic             busy,
    output logic [7:0]       rsp_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          push, pop;
    assign cmd_ready = count != (AW+1)'(DEPTH);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = state == IDLE && count != '0;
    assign busy      = state != IDLE || count != '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op1, cmd_op2, cmd_opcode};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            cnt        <= '0;
            alu_rstn   <= 1'b0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_opcode <= '0;
            rsp_count  <= '0;
        end else begin
            alu_rstn <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (pop) begin
                    {alu_op1, alu_op2, alu_opcode} <= mem[rd_ptr];
                    cnt   <= CW'(ALU_LAT);
                    state <= WAIT;
                end
                // alu_opcode is frozen until the next pop, so it still names the issued command here
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    rsp_result <= alu_result;
                    rsp_opcode <= alu_opcode;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_count <= rsp_count + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and random checks of alu_cmd_sequencer against a queue-based reference model
module tb_alu_cmd_sequencer;
    typedef struct packed {logic [3:0] a; logic [3:0] b; logic [2:0] o;} cmd_t;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst = 1, cmd_valid = 0, cmd_valid0 = 0, rsp_ready = 0, rsp_ready0 = 1;
    logic [3:0] op1 = 0, op2 = 0;
    logic [2:0] opc = 0;
    logic cmd_ready, alu_rstn, rsp_valid, busy, cmd_ready0, alu_rstn0, rsp_valid0, busy0;
    logic [3:0] alu_op1, alu_op2, alu_op1_0, alu_op2_0;
    logic [2:0] alu_opcode, rsp_opcode, alu_opcode0, rsp_opcode0;
    logic [7:0] alu_result, rsp_result, rsp_count, alu_result0, rsp_result0, rsp_count0;
    int checks = 0, errors = 0, nresp = 0;
    cmd_t q[$];

    function automatic logic [7:0] f(input logic [3:0] a, b, input logic [2:0] o);
        logic [7:0] x, y;
        x = {4'b0, a};
        y = {4'b0, b};
        case (o)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return x * y;
            3'd6: return {a, b};
            default: return ~{a, b};
        endcase
    endfunction

    // external ALU models: one-cycle registered for u1, combinational for u0
    always @(posedge clk) alu_result <= alu_rstn ? f(alu_op1, alu_op2, alu_opcode) : 8'd0;
    assign alu_result0 = f(alu_op1_0, alu_op2_0, alu_opcode0);

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1), .RES_W(8)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op1(op1), .cmd_op2(op2), .cmd_opcode(opc), .alu_rstn(alu_rstn),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_opcode(rsp_opcode), .busy(busy), .rsp_count(rsp_count));
    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(0), .RES_W(8)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op1(op1), .cmd_op2(op2), .cmd_opcode(opc), .alu_rstn(alu_rstn0),
        .alu_op1(alu_op1_0), .alu_op2(alu_op2_0), .alu_opcode(alu_opcode0), .alu_result(alu_result0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_result(rsp_result0),
        .rsp_opcode(rsp_opcode0), .busy(busy0), .rsp_count(rsp_count0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rnd_cmd();
        op1 = 4'($urandom);
        op2 = 4'($urandom);
        opc = 3'($urandom);
    endtask

    task automatic rsp_chk(input logic v, input logic r, input logic [7:0] res, input logic [2:0] o, input string tag);
        if (v && r) begin
            nresp++;
            if (q.size() == 0) chk({tag, "_spurious"}, 32'(v), 0);
            else begin
                chk({tag, "_res"}, 32'(res), 32'(f(q[0].a, q[0].b, q[0].o)));
                chk({tag, "_opc"}, 32'(o), 32'(q[0].o));
                void'(q.pop_front());
            end
        end
    endtask

    task automatic drain(input string tag);
        cmd_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            rsp_chk(rsp_valid, rsp_ready, rsp_result, rsp_opcode, tag);
            cyc();
        end
        chk({tag, "_drained"}, q.size(), 0);
        rsp_ready = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        cyc();
        q.delete();
        nresp = 0;
    endtask

    initial begin
        int acc, first_acc, last;
        cyc();
        cyc();
        // reset hold
        chk("rst_alu_rstn", 32'(alu_rstn), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_op1", 32'(alu_op1), 0);
        chk("rst_alu_op2", 32'(alu_op2), 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        chk("rst_rsp_count", 32'(rsp_count), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 0;
        cyc();
        chk("alu_rstn_release", 32'(alu_rstn), 1);
        // single op 10+3
        op1 = 4'b1010; op2 = 4'b0011; opc = 3'b000; cmd_valid = 1;
        cyc();
        cmd_valid = 0;
        chk("no_bypass", 32'(alu_op1), 0);
        chk("busy_queued", 32'(busy), 1);
        cyc();
        chk("issue_op1", 32'(alu_op1), 10);
        chk("issue_op2", 32'(alu_op2), 3);
        chk("issue_opcode", 32'(alu_opcode), 0);
        chk("wait_valid1", 32'(rsp_valid), 0);
        cyc();
        chk("wait_valid2", 32'(rsp_valid), 0);
        cyc();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_result", 32'(rsp_result), 13);
        chk("single_opcode", 32'(rsp_opcode), 0);
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        chk("single_valid_drop", 32'(rsp_valid), 0);
        chk("single_count", 32'(rsp_count), 1);
        // backpressure fill
        reset_dut();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rnd_cmd();
            cmd_valid = 1;
            if (cmd_ready) begin
                q.push_back(cmd_t'({op1, op2, opc}));
                acc++;
            end
            cyc();
        end
        chk("bp_accepted", acc, 5);
        chk("bp_full", 32'(cmd_ready), 0);
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_park_valid", 32'(rsp_valid), 1);
            chk("bp_park_result", 32'(rsp_result), 32'(f(q[0].a, q[0].b, q[0].o)));
            chk("bp_park_alu", 32'(alu_op1), 32'(q[0].a));
        end
        chk("bp_occ", 32'(u1.count), 4);
        drain("bp");
        chk("bp_count", 32'(rsp_count), 5);
        // simultaneous push/pop
        rnd_cmd(); cmd_valid = 1; q.push_back(cmd_t'({op1, op2, opc}));
        cyc();
        chk("pp_occ_before", 32'(u1.count), 1);
        rnd_cmd(); q.push_back(cmd_t'({op1, op2, opc}));
        cyc();
        cmd_valid = 0;
        chk("pp_occ_after", 32'(u1.count), 1);
        chk("pp_ready", 32'(cmd_ready), 1);
        drain("pp");
        chk("pp_count", 32'(rsp_count), 7);
        // reset during WAIT with two queued
        cmd_valid = 1;
        for (int i = 0; i < 3; i++) begin
            rnd_cmd();
            cyc();
        end
        cmd_valid = 0;
        chk("mid_occ", 32'(u1.count), 2);
        chk("mid_busy", 32'(busy), 1);
        rst = 1;
        cyc();
        rst = 0;
        chk("mid_busy_clr", 32'(busy), 0);
        chk("mid_occ_clr", 32'(u1.count), 0);
        chk("mid_count_clr", 32'(rsp_count), 0);
        chk("mid_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mid_no_rsp", 32'(rsp_valid), 0);
        end
        q.delete();
        nresp = 0;
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_cmd();
            cmd_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            rsp_chk(rsp_valid, rsp_ready, rsp_result, rsp_opcode, "rnd");
            if (cmd_valid && cmd_ready) q.push_back(cmd_t'({op1, op2, opc}));
            cyc();
        end
        drain("rnd");
        chk("rnd_count", 32'(rsp_count), 32'(8'(nresp)));
        chk("rnd_idle", 32'(busy), 0);
        // ALU_LAT=0 instance: wrap and fixed timing
        reset_dut();
        acc = 0; first_acc = 0; last = 0;
        for (int n = 0; n < 2000 && nresp < 260; n++) begin
            rnd_cmd();
            cmd_valid0 = acc < 260;
            if (rsp_valid0) begin
                if (nresp == 0) chk("lat0_first", n - first_acc, 3);
                else chk("lat0_interval", n - last, 3);
                last = n;
            end
            rsp_chk(rsp_valid0, rsp_ready0, rsp_result0, rsp_opcode0, "wrap");
            if (cmd_valid0 && cmd_ready0) begin
                if (acc == 0) first_acc = n;
                q.push_back(cmd_t'({op1, op2, opc}));
                acc++;
            end
            cyc();
        end
        cmd_valid0 = 0;
        chk("wrap_responses", nresp, 260);
        chk("wrap_count", 32'(rsp_count0), 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
